// File: rtl/kp_adapt.sv
// Loop-gain integrator: accumulates +1/-1 step decisions into kp once per
// prescaler tick, with saturation, lock detection on dithering, and freeze.
module kp_adapt #(
  parameter int          UPD_DIV    = 16,
  parameter logic [7:0]  KP_INIT    = 8'd64,
  parameter logic [7:0]  KP_MIN     = 8'd1,
  parameter logic [7:0]  KP_MAX     = 8'd254,
  parameter int          LOCK_CNT   = 8,
  parameter int          UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       freeze,
  input  logic [7:0] inc,
  output logic [7:0] kp,
  output logic       kp_valid,
  output logic       locked,
  output logic       sat_hi,
  output logic       sat_lo,
  output logic       err
);
  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  localparam int PW = $clog2(UPD_DIV);
  localparam int AW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(UNLOCK_CNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(UPD_DIV - 1);
  localparam logic [AW-1:0] LOCK_C   = AW'(LOCK_CNT);
  localparam logic [SW-1:0] UNLOCK_C = SW'(UNLOCK_CNT);

  state_t        state;
  logic [PW-1:0] pre;
  logic [AW-1:0] alt_cnt;
  logic [SW-1:0] same_cnt;
  logic          prev_vld, prev_up;

  logic          tick, up, dn, legal, rev, changed;
  logic [8:0]    kp_up9;
  logic [7:0]    kp_step;
  logic [AW-1:0] alt_inc;
  logic [SW-1:0] same_inc;

  assign tick     = (pre == PRE_LAST);
  assign up       = (inc == 8'h01);
  assign dn       = (inc == 8'hFF);
  assign legal    = up | dn;
  assign kp_up9   = {1'b0, kp} + 9'd1;
  // Up-step is widened to 9 bits so the clamp test cannot be fooled by wrap.
  assign kp_step  = up ? ((kp_up9 > {1'b0, KP_MAX}) ? KP_MAX : kp_up9[7:0])
                       : ((kp <= KP_MIN) ? KP_MIN : kp - 8'd1);
  assign changed  = (kp_step != kp);
  assign rev      = prev_vld && (prev_up != up);
  assign alt_inc  = alt_cnt + 1'b1;
  assign same_inc = same_cnt + 1'b1;
  assign sat_hi   = (kp == KP_MAX);
  assign sat_lo   = (kp == KP_MIN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      kp       <= KP_INIT;
      kp_valid <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      pre      <= '0;
      alt_cnt  <= '0;
      same_cnt <= '0;
      prev_vld <= 1'b0;
      prev_up  <= 1'b0;
    end else if (!en) begin
      state    <= IDLE;
      kp_valid <= 1'b0;
      locked   <= 1'b0;
      pre      <= '0;
      alt_cnt  <= '0;
      same_cnt <= '0;
      prev_vld <= 1'b0;
      prev_up  <= 1'b0;
    end else if (freeze) begin
      kp_valid <= 1'b0;
    end else if (state == IDLE) begin
      state    <= TRACK;
      kp_valid <= 1'b0;
    end else begin
      kp_valid <= tick;
      pre      <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        // Illegal decisions only flag err; all tracking state is left alone.
        if (!legal) begin
          err <= 1'b1;
        end else if (state == TRACK) begin
          kp       <= kp_step;
          prev_vld <= 1'b1;
          prev_up  <= up;
          if (rev && changed) begin
            if (alt_inc == LOCK_C) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              alt_cnt  <= '0;
              same_cnt <= '0;
            end else begin
              alt_cnt <= alt_inc;
            end
          end else begin
            alt_cnt <= '0;
          end
        end else begin
          prev_vld <= 1'b1;
          prev_up  <= up;
          if (prev_vld && (prev_up == up)) begin
            if (same_inc == UNLOCK_C) begin
              state    <= TRACK;
              locked   <= 1'b0;
              same_cnt <= '0;
            end else begin
              same_cnt <= same_inc;
            end
          end else begin
            same_cnt <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_kp_adapt.sv
// Bench for kp_adapt: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a tick-level model.
module tb_kp_adapt;
  localparam int UPD_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n, en, freeze;
  logic [7:0] inc;
  logic [7:0] kp;
  logic       kp_valid, locked, sat_hi, sat_lo, err;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // Model state: mode 0=idle 1=tracking 2=locked, prev 0=none +1/-1 = direction
  int m_kp, m_mode, m_pre, m_alt, m_same, m_prev;
  bit m_valid, m_err;

  kp_adapt dut (
    .clk(clk), .rst_n(rst_n), .en(en), .freeze(freeze), .inc(inc),
    .kp(kp), .kp_valid(kp_valid), .locked(locked),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_tick(input logic [7:0] d_in);
    int d, nk;
    if (d_in == 8'h01) d = 1;
    else if (d_in == 8'hFF) d = -1;
    else begin
      m_err = 1;
      return;
    end
    if (m_mode == 1) begin
      nk = m_kp + d;
      if (nk > 254) nk = 254;
      if (nk < 1) nk = 1;
      if (m_prev == -d && nk != m_kp) m_alt++;
      else m_alt = 0;
      m_prev = d;
      m_kp = nk;
      if (m_alt == 8) begin
        m_mode = 2; m_alt = 0; m_same = 0;
      end
    end else begin
      if (d == m_prev) m_same++;
      else m_same = 0;
      m_prev = d;
      if (m_same == 4) begin
        m_mode = 1; m_same = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_kp = 64; m_mode = 0; m_pre = 0; m_alt = 0; m_same = 0; m_prev = 0;
      m_valid = 0; m_err = 0;
    end else if (!en) begin
      m_mode = 0; m_pre = 0; m_alt = 0; m_same = 0; m_prev = 0; m_valid = 0;
    end else if (freeze) begin
      m_valid = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_valid = 0;
    end else begin
      m_valid = (m_pre == UPD_DIV - 1);
      m_pre = (m_pre + 1) % UPD_DIV;
      if (m_valid) model_tick(inc);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("kp", int'(kp), m_kp);
      check("kp_valid", int'(kp_valid), int'(m_valid));
      check("locked", int'(locked), int'(m_mode == 2));
      check("sat_hi", int'(sat_hi), int'(m_kp == 254));
      check("sat_lo", int'(sat_lo), int'(m_kp == 1));
      check("err", int'(err), int'(m_err));
    end
  end

  // Waits for the next kp_valid (seen at a negedge); returns cycles waited.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!kp_valid && cyc < 100);
    if (!kp_valid) check("wait_valid_timeout", cyc, -1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    rst_n = 1'b0; en = 1'b0; freeze = 1'b0; inc = 8'h01;
    repeat (2) @(negedge clk);
    chk_on = 1;
    check("rst_kp", int'(kp), 64);
    check("rst_valid", int'(kp_valid), 0);
    check("rst_err", int'(err), 0);

    // Constant up: first step after 16 counted cycles, then saturate high.
    rst_n = 1'b1; en = 1'b1;
    wait_valid(c);
    check("first_tick_lat", c, 17);
    check("first_kp", int'(kp), 65);
    repeat (189) wait_valid(c);
    check("sat_hi_kp", int'(kp), 254);
    check("sat_hi_flag", int'(sat_hi), 1);
    repeat (3) wait_valid(c);
    check("sat_hi_hold", int'(kp), 254);
    check("sat_hi_nolock", int'(locked), 0);

    // Constant down to the lower bound.
    do_reset(); inc = 8'hFF;
    repeat (63) wait_valid(c);
    check("sat_lo_kp", int'(kp), 1);
    check("sat_lo_flag", int'(sat_lo), 1);
    repeat (2) wait_valid(c);
    check("sat_lo_hold", int'(kp), 1);

    // Alternating decisions lock on the 8th reversal, then 4 same-direction ticks unlock.
    do_reset(); inc = 8'h01;
    for (int t = 1; t <= 9; t++) begin
      wait_valid(c);
      inc = (t % 2 == 1) ? 8'hFF : 8'h01;
    end
    check("lock_rise", int'(locked), 1);
    check("lock_kp", int'(kp), 65);
    inc = 8'h01;
    repeat (3) wait_valid(c);
    check("lock_hold", int'(locked), 1);
    check("lock_kp_hold", int'(kp), 65);
    wait_valid(c);
    check("unlock", int'(locked), 0);
    check("unlock_kp", int'(kp), 65);
    wait_valid(c);
    check("resume_kp", int'(kp), 66);

    // Illegal decision sets sticky err without touching kp.
    inc = 8'h37;
    wait_valid(c);
    check("err_set", int'(err), 1);
    check("err_kp", int'(kp), 66);
    inc = 8'h01;
    wait_valid(c);
    check("err_sticky", int'(err), 1);
    check("err_kp_next", int'(kp), 67);
    do_reset();
    check("err_clr", int'(err), 0);

    // Freeze mid-count, then en=0.
    en = 1'b1; inc = 8'h01;
    wait_valid(c);
    repeat (5) @(negedge clk);
    freeze = 1'b1;
    repeat (40) @(negedge clk);
    check("frz_kp", int'(kp), 65);
    freeze = 1'b0;
    wait_valid(c);
    check("frz_resume_lat", c, 11);
    check("frz_kp_after", int'(kp), 66);
    en = 1'b0;
    @(negedge clk);
    check("dis_kp", int'(kp), 66);
    check("dis_locked", int'(locked), 0);

    // Reset landing on a tick edge wins.
    do_reset(); en = 1'b1;
    wait_valid(c);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_tick_kp", int'(kp), 64);
    check("rst_tick_valid", int'(kp_valid), 0);
    rst_n = 1'b1;

    // Randomized phases; odd phases alternate on every tick to exercise locking.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 800; i++) begin
        @(negedge clk);
        if (ph % 2 == 1) begin
          if (kp_valid) inc = ($urandom_range(0, 19) == 0) ? inc : ((inc == 8'h01) ? 8'hFF : 8'h01);
        end else begin
          c = $urandom_range(0, 99);
          inc = (c < 2) ? 8'($urandom_range(2, 254)) : ((c < 55) ? 8'h01 : 8'hFF);
        end
        freeze = ($urandom_range(0, 49) == 0);
        en     = ($urandom_range(0, 299) != 0);
        rst_n  = ($urandom_range(0, 999) != 0);
      end
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
